// File: rtl/rowbias_bank_pkg.sv
// rtl/rowbias_bank_pkg.sv - shared types, widths and helpers for the row bias bank
package rowbias_pkg;

  // Default grid edge length; sets both pool size and row count unless overridden.
  localparam int GRID_LEN = 4;

  // Index width that never collapses to zero bits for degenerate sizes.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int IDX_W = clog2_min1(GRID_LEN);
  localparam int ROW_W = clog2_min1(GRID_LEN);

  // Shuffle sequencer states, one-hot encoded.
  typedef enum logic [3:0] {
    ST_INIT    = 4'b0001,
    ST_SWAP_RD = 4'b0010,
    ST_SWAP_WR = 4'b0100,
    ST_READY   = 4'b1000
  } state_t;

  // One-hot value with bit i set; callers truncate to their pool width.
  function automatic logic [31:0] onehot(input int unsigned i);
    return 32'd1 << i;
  endfunction

endpackage

// File: rtl/rowbias_bank_if.sv
// rtl/rowbias_bank_if.sv - solver-facing lookup and shuffle-control bundle
interface rowbias_bank_if
  import rowbias_pkg::*;
#(
  parameter int WIDTH      = GRID_LEN,
  parameter int NUM_ROWS   = GRID_LEN,
  parameter int RAND_WIDTH = 16
);

  logic [RAND_WIDTH-1:0]            random;
  logic                             reshuffle;
  logic                             ready;
  logic [NUM_ROWS-1:0]              update;
  logic [NUM_ROWS-1:0][WIDTH-1:0]   rqindex;
  logic [NUM_ROWS-1:0][WIDTH-1:0]   valtotry;

  // Solver / random source side.
  modport master (
    output random, reshuffle, update, rqindex,
    input  ready, valtotry
  );

  // Bias bank side.
  modport slave (
    input  random, reshuffle, update, rqindex,
    output ready, valtotry
  );

endinterface

// File: rtl/rowbias_bank_lsb_arbiter.sv
// rtl/rowbias_bank_lsb_arbiter.sv - combinational lowest-set-bit filter
module lsb_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_req,
  output logic [WIDTH-1:0] o_grant
);

  // Two's-complement trick isolates the lowest set bit; zero request gives zero grant.
  assign o_grant = i_req & (~i_req + WIDTH'(1));

endmodule

// File: rtl/rowbias_bank.sv
// rtl/rowbias_bank.sv - per-row shuffled one-hot pools with registered lookups
module rowbias_bank
  import rowbias_pkg::*;
#(
  parameter int WIDTH      = GRID_LEN,
  parameter int NUM_ROWS   = GRID_LEN,
  parameter int RAND_WIDTH = 16
) (
  input  logic          clock,
  input  logic          reset,
  rowbias_bank_if.slave bus
);

  localparam int L_IDX_W = clog2_min1(WIDTH);
  localparam int L_ROW_W = clog2_min1(NUM_ROWS);
  localparam logic [L_IDX_W-1:0] LAST_I   = L_IDX_W'(WIDTH - 1);
  localparam logic [L_ROW_W-1:0] LAST_ROW = L_ROW_W'(NUM_ROWS - 1);

  state_t                                   r_state;
  logic [L_ROW_W-1:0]                       r_row;
  logic [L_IDX_W-1:0]                       r_i;
  logic [L_IDX_W-1:0]                       r_j;
  logic [WIDTH-1:0]                         r_temp;
  logic                                     r_ready;
  logic [NUM_ROWS-1:0][WIDTH-1:0][WIDTH-1:0] r_pool;
  logic [NUM_ROWS-1:0][WIDTH-1:0]           r_valtotry;

  logic [RAND_WIDTH-1:0]                    w_div;
  logic [L_IDX_W-1:0]                       w_j;
  logic [WIDTH-1:0]                         w_new;
  logic [WIDTH-1:0]                         w_grant [NUM_ROWS];
  logic [NUM_ROWS-1:0][WIDTH-1:0]           w_sel;

  // Swap partner j is drawn uniformly-ish from 0..i; modulo bias is tolerated.
  assign w_div = RAND_WIDTH'(r_i) + RAND_WIDTH'(1);
  assign w_j   = L_IDX_W'(bus.random % w_div);
  assign w_new = WIDTH'(onehot(32'(r_i)));

  assign bus.ready    = r_ready;
  assign bus.valtotry = r_valtotry;

  // One lowest-set-bit filter per row turns a loose index into a clean one-hot select.
  for (genvar g = 0; g < NUM_ROWS; g++) begin : g_row
    lsb_arbiter #(.WIDTH(WIDTH)) u_arb (
      .i_req   (bus.rqindex[g]),
      .o_grant (w_grant[g])
    );
  end

  // AND-OR mux of each row's pool by its grant; no grant reads as the zero code.
  always_comb begin
    w_sel = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      for (int k = 0; k < WIDTH; k++) begin
        if (w_grant[r][k]) begin
          w_sel[r] = w_sel[r] | r_pool[r][k];
        end
      end
    end
  end

  // Inside-out Fisher-Yates sequencer: the only writer of the pool array.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_INIT;
      r_row   <= '0;
      r_i     <= '0;
      r_j     <= '0;
      r_temp  <= '0;
      r_ready <= 1'b0;
      r_pool  <= '0;
    end else if (bus.reshuffle) begin
      r_state <= ST_INIT;
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_row   <= '0;
          r_i     <= '0;
          r_ready <= 1'b0;
          r_state <= ST_SWAP_RD;
        end
        ST_SWAP_RD: begin
          r_j <= w_j;
          if (w_j != r_i) begin
            r_temp <= r_pool[r_row][w_j];
          end
          r_state <= ST_SWAP_WR;
        end
        ST_SWAP_WR: begin
          if (r_j != r_i) begin
            r_pool[r_row][r_i] <= r_temp;
          end
          r_pool[r_row][r_j] <= w_new;
          if (r_i == LAST_I) begin
            r_i <= '0;
            if (r_row == LAST_ROW) begin
              r_ready <= 1'b1;
              r_state <= ST_READY;
            end else begin
              r_row   <= r_row + L_ROW_W'(1);
              r_state <= ST_SWAP_RD;
            end
          end else begin
            r_i     <= r_i + L_IDX_W'(1);
            r_state <= ST_SWAP_RD;
          end
        end
        ST_READY: begin
          r_ready <= 1'b1;
        end
        default: begin
          r_ready <= 1'b0;
          r_state <= ST_INIT;
        end
      endcase
    end
  end

  // Per-row registered lookup; outside READY a strobe returns the no-value code.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_valtotry <= '0;
    end else begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        if (bus.update[r]) begin
          r_valtotry[r] <= (r_state == ST_READY) ? w_sel[r] : '0;
        end
      end
    end
  end

endmodule

// File: doc/rowbias_bank.md
# rowbias_bank

Multi-row successor to the single-row bias bus: holds NUM_ROWS independent shuffle pools, each a random permutation of the WIDTH one-hot values, and serves per-row registered lookups by one-hot index. Pools are shuffled automatically out of reset and again on every `reshuffle` pulse. A `ready` flag tells the grid solver when lookups are valid. The block sits between the LFSR random source and the per-row tile broadcast buses.

## Interface
- `WIDTH`, default `GRID_LEN`: pool size and value/index width.
- `NUM_ROWS`, default `GRID_LEN`: number of independent pools/channels.
- `RAND_WIDTH`, default 16: width of `random`; must be ≥ $clog2(WIDTH)+4.

- `clock`  in  1  single clock; all state on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `random`  in  RAND_WIDTH  free-running random word, sampled during shuffle.
- `reshuffle`  in  1  request a full reshuffle of all pools.
- `ready`  out  1  high when all pools hold complete permutations.
- `update`  in  NUM_ROWS  per-row lookup strobe.
- `rqindex`  in  NUM_ROWS×WIDTH  per-row one-hot pool index.
- `valtotry`  out  NUM_ROWS×WIDTH  per-row registered lookup result.

## Operation
- States: INIT, SWAP_RD, SWAP_WR, READY. Counters: `row` (0..NUM_ROWS-1), `i` (0..WIDTH-1), sampled `j`.
- Reset (async assert): state=INIT, all pools=0, `ready`=0, every `valtotry`=0.
- INIT: row=0, i=0 → SWAP_RD.
- SWAP_RD: j = random mod (i+1), using low bits of full `random`. If j≠i, temp=pool[row][j] → SWAP_WR.
- SWAP_WR: if j≠i, pool[row][i]=temp; pool[row][j]=1<<i. Advance i; on wrap of i, i=0 and advance row. After row NUM_ROWS-1, i WIDTH-1 → READY; otherwise → SWAP_RD. This is an inside-out Fisher–Yates shuffle; modulo bias is accepted.
- READY: `ready`=1. A `reshuffle` pulse → INIT, and `ready` drops on the same edge.
- `reshuffle` during INIT/SWAP_*: restart at INIT. Pools already written stay as-is until they are overwritten.
- Lookup, per row r, on an edge with update[r]=1:
  - If not READY, valtotry[r]=0.
  - Otherwise, valtotry[r]=pool[r][k], where k is the lowest set bit of rqindex[r].
  - rqindex[r]=0 yields 0, the reserved "no value" code.
- update[r]=0 holds valtotry[r].

## Timing
- Lookup latency is 1 cycle: result is visible after the edge that samples update[r].
- Full shuffle takes 1 + 2·WIDTH·NUM_ROWS edges from INIT to `ready`=1. Example: WIDTH=4, NUM_ROWS=2 gives `ready` high after the 17th edge following reset release.
- `update` coincident with `reshuffle` in READY: the lookup is served from the pre-shuffle pool. Subsequent lookups return 0 until `ready` returns.
- Rows are independent. Simultaneous updates on all rows are served in the same cycle.
- `ready` and `valtotry` are registered outputs with no combinational path from inputs.

## Structure
- Package `rowbias_pkg`:
  - state enum (one-hot encoded);
  - localparams `IDX_W=$clog2(WIDTH)` and `ROW_W=$clog2(NUM_ROWS)`;
  - function `onehot(i)`.
- Sub-module `lsb_arbiter #(WIDTH)`: combinational lowest-set-bit filter. One instance per row on `rqindex`.
- Pool storage is a NUM_ROWS×WIDTH×WIDTH register array. Only the single shared shuffle sequencer writes it.

## Test plan
All scenarios use WIDTH=4, NUM_ROWS=2, RAND_WIDTH=8.
- Reset release with `random`=0 → `ready`=0 for 16 edges, =1 after edge 17. Both pools are [1000,0001,0010,0100]; rqindex=0001 → 1000, rqindex=0010 → 0001 one cycle later.
- `random`=8'hFF throughout → both pools [0100,0010,0001,1000]; rqindex=1000 → 1000.
- In READY, rqindex=0110 → pool[1]. rqindex=0000 → 0000. `update` low for 5 cycles → `valtotry` unchanged.
- `reshuffle` at edge 10 of the initial shuffle → `ready` stays 0 until 17 edges after the restart. `update` meanwhile → 0000.
- `reshuffle` and update[0] on the same READY edge → old pool value returned; `ready`=0 next cycle.
- Assert `reset` mid-READY between clock edges → `ready` and all `valtotry` read 0 immediately, with no clock edge needed.
